// File: rtl/nrom_cart_loader.sv
// NROM cartridge: loads an iNES image over a byte handshake, then serves CPU/PPU reads.
// Optional 8KB-class PRG-RAM at $6000-$7FFF is built when CART_PRG_RAM_EN is defined.
module nrom_cart_loader #(
    parameter int PRG_BANKS_MAX = 2,
    parameter int CHR_BANKS_MAX = 1,
    parameter int PRG_RAM_AW    = 13
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst,
    input  logic        i_prog,
    input  logic        i_prog_valid,
    input  logic [7:0]  i_prog_di,
    output logic        o_prog_ready,
    output logic        o_load_done,
    output logic        o_load_err,
    input  logic [15:0] i_cpu_ab,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_cpu_di,
    output logic [7:0]  o_cpu_do,
    output logic        o_cpu_hit,
    input  logic [13:0] i_ppu_ab,
    output logic [7:0]  o_ppu_do,
    output logic        o_ciram_a10,
    output logic [2:0]  o_dbg_state
);

    localparam int PRG_DEPTH = 16384 * PRG_BANKS_MAX;
    localparam int PRG_AW    = $clog2(PRG_DEPTH);
    localparam int CHR_DEPTH = 8192;
    localparam int CNT_W     = PRG_AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PRG  = 3'd2,
        S_CHR  = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_prg_banks;
    logic [7:0]         r_chr_banks;
    logic               r_mirror_v;
    logic               r_prog_d;

    logic               w_loading;
    logic               w_run;
    logic               w_xfer;
    logic               w_prog_rise;
    logic               w_hdr_ok;
    logic [CNT_W-1:0]   w_prg_end;
    logic [CNT_W-1:0]   w_chr_end;
    logic [PRG_AW-1:0]  w_prg_idx;
    logic               w_ram_sel;
    logic               w_ram_en;
    logic [7:0]         w_ram_rd;

    logic [7:0] r_prg_mem [PRG_DEPTH];
    logic [7:0] r_chr_mem [CHR_DEPTH];

    // Handshake: a byte moves on a cycle where i_prog_valid and o_prog_ready are both high;
    // o_prog_ready is high only in HDR/PRG/CHR while i_prog is held high.
    assign w_loading    = (r_state == S_HDR) || (r_state == S_PRG) || (r_state == S_CHR);
    assign w_run        = (r_state == S_RUN);
    assign o_prog_ready = w_loading & i_prog;
    assign w_xfer       = i_prog_valid & o_prog_ready;
    assign w_prog_rise  = i_prog & ~r_prog_d;
    assign o_dbg_state  = r_state;

    assign w_prg_end = CNT_W'({r_prg_banks, 14'd0} - 22'd1);
    assign w_chr_end = CNT_W'({r_chr_banks, 13'd0} - 21'd1);

    always_comb begin
        w_hdr_ok = 1'b1;
        case (r_cnt[3:0])
            4'd0:    w_hdr_ok = (i_prog_di == 8'h4E);
            4'd1:    w_hdr_ok = (i_prog_di == 8'h45);
            4'd2:    w_hdr_ok = (i_prog_di == 8'h53);
            4'd3:    w_hdr_ok = (i_prog_di == 8'h1A);
            4'd4:    w_hdr_ok = (i_prog_di >= 8'd1) && (i_prog_di <= 8'(PRG_BANKS_MAX));
            4'd5:    w_hdr_ok = (i_prog_di >= 8'd1) && (i_prog_di <= 8'(CHR_BANKS_MAX));
            4'd6:    w_hdr_ok = ~i_prog_di[2];
            default: w_hdr_ok = 1'b1;
        endcase
    end

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_prg_banks <= 8'd0;
            r_chr_banks <= 8'd0;
            r_mirror_v  <= 1'b0;
            r_prog_d    <= 1'b0;
            o_load_done <= 1'b0;
            o_load_err  <= 1'b0;
        end else begin
            r_prog_d <= i_prog;
            if (w_prog_rise) begin
                r_state     <= S_HDR;
                r_cnt       <= '0;
                o_load_done <= 1'b0;
                o_load_err  <= 1'b0;
            end else if (w_loading && !i_prog) begin
                r_state    <= S_ERR;
                o_load_err <= 1'b1;
            end else if (w_xfer) begin
                case (r_state)
                    S_HDR: begin
                        if (!w_hdr_ok) begin
                            r_state    <= S_ERR;
                            o_load_err <= 1'b1;
                        end else begin
                            if (r_cnt[3:0] == 4'd4) r_prg_banks <= i_prog_di;
                            if (r_cnt[3:0] == 4'd5) r_chr_banks <= i_prog_di;
                            if (r_cnt[3:0] == 4'd6) r_mirror_v  <= i_prog_di[0];
                            if (r_cnt[3:0] == 4'd15) begin
                                r_state <= S_PRG;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_PRG: begin
                        if (r_cnt == w_prg_end) begin
                            r_state <= S_CHR;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_CHR: begin
                        if (r_cnt == w_chr_end) begin
                            r_state     <= S_RUN;
                            o_load_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // Image stores are never reset: a reload simply overwrites them.
    always_ff @(posedge i_cpu_clk) begin
        if (w_xfer && (r_state == S_PRG)) r_prg_mem[r_cnt] <= i_prog_di;
        if (w_xfer && (r_state == S_CHR)) r_chr_mem[r_cnt[12:0]] <= i_prog_di;
    end

    // NROM-128 mirrors its single 16KB bank into both $8000 and $C000.
    assign w_prg_idx = (r_prg_banks == 8'd1) ? PRG_AW'(i_cpu_ab[13:0]) : PRG_AW'(i_cpu_ab[14:0]);
    assign w_ram_sel = (i_cpu_ab[15:13] == 3'b011);

`ifdef CART_PRG_RAM_EN
    logic [7:0] r_ram [2**PRG_RAM_AW];

    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_we && w_ram_sel) r_ram[i_cpu_ab[PRG_RAM_AW-1:0]] <= i_cpu_di;
    end

    assign w_ram_rd = r_ram[i_cpu_ab[PRG_RAM_AW-1:0]];
    assign w_ram_en = 1'b1;
`else
    logic w_unused_ram;
    assign w_unused_ram = ^{i_cpu_we, i_cpu_di};
    assign w_ram_rd     = 8'h00;
    assign w_ram_en     = 1'b0;
`endif

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cpu_do  <= 8'h00;
            o_cpu_hit <= 1'b0;
            o_ppu_do  <= 8'h00;
        end else begin
            o_cpu_do  <= 8'h00;
            o_cpu_hit <= 1'b0;
            if (w_run && i_cpu_ab[15]) begin
                o_cpu_do  <= r_prg_mem[w_prg_idx];
                o_cpu_hit <= 1'b1;
            end else if (w_ram_sel && w_ram_en) begin
                o_cpu_do  <= w_ram_rd;
                o_cpu_hit <= 1'b1;
            end
            o_ppu_do <= (w_run && !i_ppu_ab[13]) ? r_chr_mem[i_ppu_ab[12:0]] : 8'h00;
        end
    end

    assign o_ciram_a10 = w_run & (r_mirror_v ? i_ppu_ab[10] : i_ppu_ab[11]);

endmodule
